// File: rtl/sort_pru.sv
// Counting-sort readout engine: walks every bin of a count memory, emits each
// key as many times as its count, and clears each bin once it is drained.
module sort_pru #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl2pru_start_vld_i,
  output logic              pru2ctrl_rd_done_vld_o,
  output logic              pru2mem_rd_en_o,
  output logic [DATA_W-1:0] pru2mem_rd_addr_o,
  input  logic [CNT_W-1:0]  mem2pru_rd_data_i,
  output logic              pru2mem_clr_en_o,
  output logic [DATA_W-1:0] pru2mem_clr_addr_o,
  output logic              pru_out_vld_o,
  output logic [DATA_W-1:0] pru_out_data_o,
  input  logic              pru_out_rdy_i,
  output logic              pru_busy_o
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, EMIT, DONE} state_t;

  localparam logic [DATA_W-1:0] ADDR_MAX = '1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] addr, addr_nxt;
  logic [CNT_W-1:0]  remain, remain_nxt;
  logic              bin_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      remain <= remain_nxt;
    end
  end

  always_comb begin
    state_nxt              = state;
    addr_nxt               = addr;
    remain_nxt             = remain;
    bin_done               = 1'b0;
    pru2mem_rd_en_o        = 1'b0;
    pru2mem_clr_en_o       = 1'b0;
    pru_out_vld_o          = 1'b0;
    pru2ctrl_rd_done_vld_o = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl2pru_start_vld_i) begin
          addr_nxt  = '0;
          state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        pru2mem_rd_en_o = 1'b1;
        state_nxt       = RD_WAIT;
      end
      RD_WAIT: begin
        remain_nxt = mem2pru_rd_data_i;
        if (mem2pru_rd_data_i == '0) bin_done = 1'b1;
        else                         state_nxt = EMIT;
      end
      EMIT: begin
        pru_out_vld_o = 1'b1;
        // remain != 0 guard keeps the counter from wrapping
        if (pru_out_rdy_i && remain != '0) begin
          remain_nxt = remain - 1'b1;
          if (remain == CNT_W'(1)) bin_done = 1'b1;
        end
      end
      DONE: begin
        pru2ctrl_rd_done_vld_o = 1'b1;
        state_nxt              = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bin_done) begin
      pru2mem_clr_en_o = 1'b1;
      if (addr == ADDR_MAX) begin
        state_nxt = DONE;
      end else begin
        addr_nxt  = addr + 1'b1;
        state_nxt = RD_REQ;
      end
    end
  end

  assign pru2mem_rd_addr_o  = addr;
  assign pru2mem_clr_addr_o = addr;
  assign pru_out_data_o     = addr;
  assign pru_busy_o         = (state != IDLE);

endmodule
